// File: rtl/log_mult_pipe.sv
// log_mult_pipe: 3-stage Mitchell log-domain multiplier with a valid/ready handshake.
// Define LOG_MULT_SAT_EN to saturate out_prod to all ones on overflow (wraps otherwise).
module log_mult_pipe #(
    parameter int K_W   = 5,
    parameter int M1_W  = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K_W-1:0]   a_k,
    input  logic [M1_W-1:0]  a_m1,
    input  logic             a_zero,
    input  logic [K_W-1:0]   b_k,
    input  logic [M1_W-1:0]  b_m1,
    input  logic             b_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_prod,
    output logic             out_ovf
);
    localparam int           P_W   = 2 * (1 << K_W);
    localparam logic [K_W:0] M1_SH = (K_W+1)'(M1_W);

    logic             w_en;
    logic [M1_W:0]    w_f;
    logic [K_W:0]     w_ks;
    logic             r_s1_valid;
    logic             r_s1_z;
    logic [K_W:0]     r_s1_ks;
    logic [M1_W-1:0]  r_s1_frac;
    logic [P_W-1:0]   w_mant;
    logic [P_W-1:0]   w_p;
    logic             r_s2_valid;
    logic [P_W-1:0]   r_s2_p;
    logic             w_ovf;
    logic [OUT_W-1:0] w_prod;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_prod;
    logic             r_out_ovf;

    // Single global enable: the whole pipe stalls together, bubbles are kept.
    assign w_en     = out_ready | ~r_out_valid;
    assign in_ready = w_en;

    assign w_f  = {1'b0, a_m1} + {1'b0, b_m1};
    assign w_ks = {1'b0, a_k} + {1'b0, b_k} + {{K_W{1'b0}}, w_f[M1_W]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_z     <= 1'b0;
            r_s1_ks    <= '0;
            r_s1_frac  <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_z     <= a_zero | b_zero;
            r_s1_ks    <= w_ks;
            r_s1_frac  <= w_f[M1_W-1:0];
        end
    end

    assign w_mant = {{(P_W-M1_W-1){1'b0}}, 1'b1, r_s1_frac};

    // (mant << ks) >> M1_W done as one shift whose direction depends on ks,
    // so the top mantissa bit is never lost at ks = 2*2^K_W - 1.
    always_comb begin
        w_p = '0;
        if (!r_s1_z) begin
            if (r_s1_ks >= M1_SH) begin
                w_p = w_mant << (r_s1_ks - M1_SH);
            end else begin
                w_p = w_mant >> (M1_SH - r_s1_ks);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_p     <= w_p;
        end
    end

    generate
        if (OUT_W < P_W) begin : g_ovf
            assign w_ovf = |r_s2_p[P_W-1:OUT_W];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

`ifdef LOG_MULT_SAT_EN
    assign w_prod = w_ovf ? '1 : r_s2_p[OUT_W-1:0];
`else
    assign w_prod = r_s2_p[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            r_out_prod  <= w_prod;
            r_out_ovf   <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign out_prod  = r_out_prod;
    assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_log_mult_pipe.sv
// Self-checking bench for log_mult_pipe (OUT_W=32 and OUT_W=64 instances share stimulus).
// Expected products come from a Mitchell model on the raw 32-bit operands.
module tb_log_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  a_k = '0, b_k = '0;
    logic [7:0]  a_m1 = '0, b_m1 = '0;
    logic        a_zero = 1'b0, b_zero = 1'b0;
    logic        in_ready32, out_valid32, out_ovf32;
    logic [31:0] out_prod32;
    logic        in_ready64, out_valid64, out_ovf64;
    logic [63:0] out_prod64;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    log_mult_pipe #(.K_W(5), .M1_W(8), .OUT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .a_k(a_k), .a_m1(a_m1), .a_zero(a_zero), .b_k(b_k), .b_m1(b_m1), .b_zero(b_zero),
        .out_valid(out_valid32), .out_ready(out_ready), .out_prod(out_prod32), .out_ovf(out_ovf32)
    );

    log_mult_pipe #(.K_W(5), .M1_W(8), .OUT_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .a_k(a_k), .a_m1(a_m1), .a_zero(a_zero), .b_k(b_k), .b_m1(b_m1), .b_zero(b_zero),
        .out_valid(out_valid64), .out_ready(out_ready), .out_prod(out_prod64), .out_ovf(out_ovf64)
    );

    function automatic logic [4:0] op_k(input logic [31:0] v);
        logic [4:0] k;
        k = '0;
        for (int i = 0; i < 32; i++) if (v[i]) k = 5'(i);
        return k;
    endfunction

    function automatic logic [7:0] op_m1(input logic [31:0] v);
        logic [39:0] w;
        w = {v, 8'h00};
        return w[op_k(v) +: 8];
    endfunction

    // log2(x) ~= k + m1/256; product ~= 2^I * (1 + F/256), floored
    function automatic logic [127:0] model_p(input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [127:0] r;
        if (a == 0 || b == 0) return '0;
        s = int'(op_k(a)) * 256 + int'(op_m1(a)) + int'(op_k(b)) * 256 + int'(op_m1(b));
        r = 128'(256 + (s % 256));
        r = r << (s / 256);
        return r >> 8;
    endfunction

    function automatic logic [31:0] exp_p32(input logic [127:0] p);
`ifdef LOG_MULT_SAT_EN
        if (p[127:32] != '0) return '1;
`endif
        return p[31:0];
    endfunction

    function automatic logic [63:0] exp_p64(input logic [127:0] p);
`ifdef LOG_MULT_SAT_EN
        if (p[127:64] != '0) return '1;
`endif
        return p[63:0];
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic drive_ops(input logic [31:0] a, input logic [31:0] b);
        a_k = op_k(a); a_m1 = op_m1(a); a_zero = (a == 0);
        b_k = op_k(b); b_m1 = op_m1(b); b_zero = (b == 0);
    endtask

    // Issues one pair into an empty pipe with out_ready=1 and captures the first output.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p32, output logic [63:0] p64,
                                  output logic o32, output logic o64, output int lat);
        p32 = '0; p64 = '0; o32 = 1'b0; o64 = 1'b0; lat = -1;
        @(posedge clk); #1;
        drive_ops(a, b); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            #1;
            if (out_valid32) begin
                p32 = out_prod32; p64 = out_prod64; o32 = out_ovf32; o64 = out_ovf64; lat = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_valid32: got %b expected 0", out_valid32); end
        checks++; if (out_valid64 !== 1'b0) begin errors++; $display("FAIL reset_valid64: got %b expected 0", out_valid64); end
        checks++; if (out_prod32 !== 32'h0) begin errors++; $display("FAIL reset_prod32: got %h expected 0", out_prod32); end
        checks++; if (out_ovf32 !== 1'b0) begin errors++; $display("FAIL reset_ovf32: got %b expected 0", out_ovf32); end
        checks++; if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready32, in_ready64); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [31:0] p32; logic [63:0] p64; logic o32, o64; int lat;
        issue_and_wait(32'd4, 32'd4, p32, p64, o32, o64, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL latency_4x4: got %0d expected 3", lat); end
        checks++; if (p32 !== 32'd16 || o32 !== 1'b0) begin errors++; $display("FAIL prod_4x4: got %0d ovf %b expected 16 ovf 0", p32, o32); end
        checks++; if (p64 !== 64'd16) begin errors++; $display("FAIL prod64_4x4: got %0d expected 16", p64); end
    endtask

    task automatic test_mitchell();
        logic [31:0] p32; logic [63:0] p64; logic o32, o64; int lat;
        issue_and_wait(32'd3, 32'd5, p32, p64, o32, o64, lat);
        checks++; if (p32 !== 32'd14 || lat != 3) begin errors++; $display("FAIL prod_3x5: got %0d lat %0d expected 14 lat 3", p32, lat); end
        issue_and_wait(32'd3, 32'd3, p32, p64, o32, o64, lat);
        checks++; if (p32 !== 32'd8 || o32 !== 1'b0) begin errors++; $display("FAIL prod_3x3_carry: got %0d ovf %b expected 8 ovf 0", p32, o32); end
    endtask

    task automatic test_zero();
        logic [31:0] p32; logic [63:0] p64; logic o32, o64; int lat;
        issue_and_wait(32'h0, 32'hFFFF_FFFF, p32, p64, o32, o64, lat);
        checks++; if (p32 !== 32'h0 || o32 !== 1'b0) begin errors++; $display("FAIL zero32: got %h ovf %b expected 0 ovf 0", p32, o32); end
        checks++; if (p64 !== 64'h0 || o64 !== 1'b0) begin errors++; $display("FAIL zero64: got %h ovf %b expected 0 ovf 0", p64, o64); end
    endtask

    task automatic test_boundaries();
        logic [31:0] p32; logic [63:0] p64; logic o32, o64; int lat;
        logic [31:0] ovf_word;
`ifdef LOG_MULT_SAT_EN
        ovf_word = 32'hFFFF_FFFF;
`else
        ovf_word = 32'h0000_0000;
`endif
        issue_and_wait(32'hFFFF_FFFF, 32'hFFFF_FFFF, p32, p64, o32, o64, lat);
        checks++; if (p64 !== 64'hFF00_0000_0000_0000 || o64 !== 1'b0) begin errors++; $display("FAIL max64: got %h ovf %b expected ff00000000000000 ovf 0", p64, o64); end
        checks++; if (p32 !== ovf_word || o32 !== 1'b1) begin errors++; $display("FAIL max32: got %h ovf %b expected %h ovf 1", p32, o32, ovf_word); end
        issue_and_wait(32'h0001_0000, 32'h0001_0000, p32, p64, o32, o64, lat);
        checks++; if (p32 !== ovf_word || o32 !== 1'b1) begin errors++; $display("FAIL ovf_2p32: got %h ovf %b expected %h ovf 1", p32, o32, ovf_word); end
        checks++; if (p64 !== 64'h1_0000_0000 || o64 !== 1'b0) begin errors++; $display("FAIL p64_2p32: got %h ovf %b expected 100000000 ovf 0", p64, o64); end
    endtask

    task automatic test_stall_stream();
        localparam int N = 8;
        logic [31:0] oa [N];
        logic [31:0] ob [N];
        logic [127:0] p;
        bit mv [3];
        int mi [3];
        int sent, recv, cyc;
        bit en_m;
        for (int i = 0; i < N; i++) begin oa[i] = rand_op(); ob[i] = rand_op(); end
        for (int s = 0; s < 3; s++) begin mv[s] = 1'b0; mi[s] = 0; end
        sent = 0; recv = 0; cyc = 0;
        while (recv < N && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            in_valid = (sent < N);
            if (sent < N) drive_ops(oa[sent], ob[sent]);
            #1;
            en_m = out_ready || !mv[2];
            checks++; if (in_ready32 !== en_m) begin errors++; $display("FAIL stall_in_ready cyc %0d: got %b expected %b", cyc, in_ready32, en_m); end
            checks++; if (out_valid32 !== mv[2]) begin errors++; $display("FAIL stall_out_valid cyc %0d: got %b expected %b", cyc, out_valid32, mv[2]); end
            if (mv[2]) begin
                p = model_p(oa[mi[2]], ob[mi[2]]);
                checks++;
                if (out_prod32 !== exp_p32(p) || out_ovf32 !== (p[127:32] != '0) || out_prod64 !== exp_p64(p)) begin
                    errors++;
                    $display("FAIL stall_data item %0d cyc %0d: got %h/%b/%h expected %h/%b/%h", mi[2], cyc,
                             out_prod32, out_ovf32, out_prod64, exp_p32(p), (p[127:32] != '0), exp_p64(p));
                end
            end
            if (en_m) begin
                if (mv[2] && out_ready) recv++;
                mv[2] = mv[1]; mi[2] = mi[1];
                mv[1] = mv[0]; mi[1] = mi[0];
                mv[0] = in_valid; mi[0] = sent;
                if (in_valid) sent++;
            end
            cyc++;
        end
        checks++; if (recv != N) begin errors++; $display("FAIL stall_count: got %0d expected %0d", recv, N); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 20;
        localparam int C = 32;
        logic [31:0] oa [N];
        logic [31:0] ob [N];
        bit hv [C];
        int hi [C];
        logic [127:0] p;
        int sent, recv;
        for (int i = 0; i < N; i++) begin oa[i] = rand_op(); ob[i] = rand_op(); end
        sent = 0; recv = 0;
        for (int c = 0; c < C; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = (sent < N) && ((c % 7) != 5);
            if (in_valid) drive_ops(oa[sent], ob[sent]);
            hv[c] = in_valid; hi[c] = sent;
            #1;
            checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", c, in_ready32); end
            checks++; if (out_valid32 !== (c >= 3 && hv[c >= 3 ? c - 3 : 0])) begin errors++; $display("FAIL b2b_out_valid cyc %0d: got %b", c, out_valid32); end
            if (c >= 3 && hv[c - 3]) begin
                p = model_p(oa[hi[c - 3]], ob[hi[c - 3]]);
                checks++;
                if (out_prod32 !== exp_p32(p) || out_prod64 !== exp_p64(p)) begin
                    errors++;
                    $display("FAIL b2b_data item %0d: got %h/%h expected %h/%h", hi[c - 3], out_prod32, out_prod64, exp_p32(p), exp_p64(p));
                end
                recv++;
            end
            if (in_valid) sent++;
        end
        in_valid = 1'b0;
        checks++; if (recv != N) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", recv, N); end
    endtask

    task automatic test_midflight_reset();
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; drive_ops(32'd7, 32'd9);
        @(posedge clk); #1;
        drive_ops(32'd100, 32'd200);
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b/%b expected 0/0", out_valid32, out_valid64); end
        checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready32); end
        checks++; if (out_prod32 !== 32'h0) begin errors++; $display("FAIL midreset_prod: got %h expected 0", out_prod32); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL midreset_stale cyc %0d: got %b expected 0", c, out_valid32); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_mitchell();
        test_zero();
        test_boundaries();
        test_stall_stream();
        test_back_to_back();
        test_midflight_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
